text_console_ctrl: RTL and testbench
====================================

Name: text_console_ctrl

Overview:
Write-side controller for the 32x16 character text buffer scanned by the tile layer. Accepts a byte stream over a valid/ready handshake and interprets control codes such as newline, carriage return, backspace and form feed. Owns cursor position and hardware scroll offset, and sequences all text-buffer writes, including bulk clears. Writes are issued only while the display is outside the active area, so the write port never competes with the tile layer's scan reads.

Parameters:
COLS, 32, characters per row; power of two; COL_BITS = log2(COLS) = 5.
ROWS, 16, character rows; power of two; ROW_BITS = log2(ROWS) = 4.
BLANK_CHAR, 8'h20, fill byte for clears and backspace.
BLINK_FRAMES, 30, frames per cursor blink phase (optional feature only).

Ports:
i_pix_clk  in  1  pixel clock; sole clock.
i_reset_n  in  1  reset, synchronous, active-low.
i_in_active_area  in  1  1 = scan in visible area; writes are forbidden.
i_char_valid  in  1  input byte valid.
i_char  in  8  input byte.
o_char_ready  out  1  controller can accept a byte this cycle.
o_wr_en  out  1  text-buffer write strobe.
o_wr_addr  out  9  text-buffer address {phys_row[3:0], col[4:0]}.
o_wr_data  out  8  text-buffer write data.
o_row_offset  out  4  physical row shown at the top of the screen; the tile layer adds it to its row index mod ROWS.
o_cursor_col  out  5  logical cursor column.
o_cursor_row  out  4  logical cursor row (0 = top of screen).
o_busy  out  1  state != IDLE.

Behaviour:
- Reset (i_reset_n=0 at a clock edge):
  - cursor = (0,0); o_row_offset=0; o_wr_addr=0; o_wr_data=BLANK_CHAR.
  - state = CLEAR_ALL; o_char_ready=0; o_wr_en=0 while in reset.
  - Reset asserted mid-operation abandons the operation and restarts CLEAR_ALL from address 0.
- Physical row: phys_row = (cursor_row + o_row_offset) mod ROWS.
- o_wr_en = (state in {WRITE_CHAR, CLEAR_LINE, CLEAR_ALL}) && !i_in_active_area. This is combinational. o_wr_addr and o_wr_data are registered and stable until the write fires.
- o_char_ready = (state == IDLE). A byte is accepted on a cycle where valid && ready.
- IDLE, on byte accept:
  - 0x20..0x7E: load addr = {phys_row, col}, data = byte; go to WRITE_CHAR.
  - 0x0A: col=0, then ADVANCE.
  - 0x0D: col=0; stay in IDLE.
  - 0x08 with col>0: col--; load BLANK_CHAR at the new col; go to WRITE_CHAR with no advance afterwards.
  - 0x08 with col=0: no-op.
  - 0x0C: cursor=(0,0), o_row_offset=0; go to CLEAR_ALL.
  - Any other byte: consumed and ignored.
- WRITE_CHAR: waits until o_wr_en=1. On that cycle:
  - For a printable byte, col++. If col was COLS-1, col=0 and then ADVANCE.
  - Otherwise return to IDLE.
- ADVANCE (not a state; the transition taken in the same cycle):
  - cursor_row<ROWS-1: cursor_row++, go to IDLE.
  - cursor_row==ROWS-1: go to CLEAR_LINE targeting phys row o_row_offset (the top row); cursor_row stays ROWS-1.
- CLEAR_LINE: writes BLANK_CHAR to cols 0..COLS-1, one per cycle with o_wr_en=1. On the final write, o_row_offset increments mod ROWS, then go to IDLE. The offset does not change before the line is blank, so a stale line is never displayed.
- CLEAR_ALL: writes BLANK_CHAR to addresses 0..511 in ascending order, one per permitted cycle, then goes to IDLE.
- In all write states, a cycle with i_in_active_area=1 stalls the counter and address; nothing is skipped.
- A byte presented while busy is held by the sender (ready=0) and accepted unchanged on the first IDLE cycle.
- Column and row counters wrap mod COLS/ROWS; no out-of-range addresses are ever driven.

Optional Feature:
TEXT_CONSOLE_CURSOR_BLINK_EN:
- Defined:
  - Adds input i_frame_start (1-cycle pulse per frame) and output o_cursor_on.
  - A frame counter toggles o_cursor_on every BLINK_FRAMES pulses.
  - o_cursor_on is forced to 1 for BLINK_FRAMES frames after any accepted byte.
  - Reset value of o_cursor_on: 1.
- Undefined: neither port exists; no blink logic.

Decomposition:
- Shared include/package text_console_defs:
  - Control-code constants CHR_BS=8'h08, CHR_LF=8'h0A, CHR_FF=8'h0C, CHR_CR=8'h0D.
  - State encodings IDLE, WRITE_CHAR, CLEAR_LINE, CLEAR_ALL.
  - COLS/ROWS defaults, shared with the tile layer.
- One sub-module, cursor_blink_timer, holds the frame counter and o_cursor_on. It is instantiated only under TEXT_CONSOLE_CURSOR_BLINK_EN.

Test Plan:
1. Hold i_reset_n=0 for 3 cycles, release with i_in_active_area=0 → 512 consecutive writes, addr 0..511, data 0x20; then o_busy=0, o_char_ready=1, cursor (0,0), offset 0.
2. Send 0x41 → single write addr 0, data 0x41; cursor col=1. Send 0x42 while i_in_active_area=1 for 10 cycles → o_wr_en stays 0; write addr 1 fires on the first cycle the area drops.
3. Send 32 printable bytes → writes addr 0..31, cursor (row1,col0). Then 0x41 x5 and 0x08 → write 0x20 at addr {1,4}=36; cursor col=4. 0x0D → col=0, no write.
4. From (0,0), send 15×0x0A → cursor row 15, no writes. 16th 0x0A → 32 writes addr 0..31 data 0x20, then o_row_offset=1, cursor row 15. 0x43 → write addr {4'd0,5'd0}=0.
5. Reset asserted mid-CLEAR_LINE (after 10 writes) → restart CLEAR_ALL from addr 0, offset 0.
6. Mid-screen 0x0C → 512 clears, offset 0, cursor (0,0); 0x07 → ignored, no write, ready stays 1.

Source files
------------

// File: rtl/text_console_ctrl_pkg.sv
// Shared definitions for the text console: geometry, control codes and
// controller state encodings. Also used by the tile layer for COLS/ROWS.
package text_console_defs;

  localparam int COLS      = 32;
  localparam int ROWS      = 16;
  localparam int COL_BITS  = 5;
  localparam int ROW_BITS  = 4;
  localparam int ADDR_BITS = ROW_BITS + COL_BITS;

  localparam int BLINK_FRAMES = 30;

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam logic [7:0] CHR_BS     = 8'h08;
  localparam logic [7:0] CHR_LF     = 8'h0A;
  localparam logic [7:0] CHR_FF     = 8'h0C;
  localparam logic [7:0] CHR_CR     = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE_CHAR = 2'd1,
    ST_CLEAR_LINE = 2'd2,
    ST_CLEAR_ALL  = 2'd3
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/cursor_blink_timer.sv
// Cursor blink phase generator; present only when TEXT_CONSOLE_CURSOR_BLINK_EN
// is defined. Any accepted byte restarts a full "on" phase.
`ifdef TEXT_CONSOLE_CURSOR_BLINK_EN
module cursor_blink_timer
  import text_console_defs::*;
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_frame_start,
  input  logic i_kick,
  output logic o_cursor_on
);

  localparam int CNT_W = $clog2(BLINK_FRAMES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_on;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
      r_on  <= 1'b1;
    end else if (i_kick) begin
      r_cnt <= '0;
      r_on  <= 1'b1;
    end else if (i_frame_start) begin
      if (r_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        r_cnt <= '0;
        r_on  <= ~r_on;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cursor_on = r_on;

endmodule
`endif

// File: rtl/text_console_ctrl.sv
// Write-side controller for the 32x16 text buffer. Optional cursor blink is
// enabled by defining TEXT_CONSOLE_CURSOR_BLINK_EN.
module text_console_ctrl
  import text_console_defs::*;
(
  input  logic                 i_pix_clk,
  input  logic                 i_reset_n,
  input  logic                 i_in_active_area,
  input  logic                 i_char_valid,
  input  logic [7:0]           i_char,
  output logic                 o_char_ready,
  output logic                 o_wr_en,
  output logic [ADDR_BITS-1:0] o_wr_addr,
  output logic [7:0]           o_wr_data,
  output logic [ROW_BITS-1:0]  o_row_offset,
  output logic [COL_BITS-1:0]  o_cursor_col,
  output logic [ROW_BITS-1:0]  o_cursor_row,
  output logic                 o_busy
`ifdef TEXT_CONSOLE_CURSOR_BLINK_EN
  ,
  input  logic                 i_frame_start,
  output logic                 o_cursor_on
`endif
);

  state_e                r_state,    w_state_nxt;
  logic [COL_BITS-1:0]   r_col,      w_col_nxt;
  logic [ROW_BITS-1:0]   r_row,      w_row_nxt;
  logic [ROW_BITS-1:0]   r_offset,   w_offset_nxt;
  logic [ADDR_BITS-1:0]  r_wr_addr,  w_wr_addr_nxt;
  logic [7:0]            r_wr_data,  w_wr_data_nxt;
  logic                  r_step_col, w_step_col_nxt;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_wr_en;
  logic                  w_advance;
  logic [ROW_BITS-1:0]   w_phys_row;
  logic [COL_BITS-1:0]   w_col_dec;

  // Reset gates the handshake and strobe so nothing escapes while held.
  assign w_ready    = i_reset_n && (r_state == ST_IDLE);
  assign w_accept   = w_ready && i_char_valid;
  assign w_wr_en    = i_reset_n && (r_state != ST_IDLE) && !i_in_active_area;
  assign w_phys_row = r_row + r_offset;
  assign w_col_dec  = r_col - 5'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_col_nxt      = r_col;
    w_row_nxt      = r_row;
    w_offset_nxt   = r_offset;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_step_col_nxt = r_step_col;
    w_advance      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_printable(i_char)) begin
            w_wr_addr_nxt  = {w_phys_row, r_col};
            w_wr_data_nxt  = i_char;
            w_step_col_nxt = 1'b1;
            w_state_nxt    = ST_WRITE_CHAR;
          end else begin
            case (i_char)
              CHR_LF: begin
                w_col_nxt = '0;
                w_advance = 1'b1;
              end
              CHR_CR: w_col_nxt = '0;
              CHR_BS: begin
                if (r_col != '0) begin
                  w_col_nxt      = w_col_dec;
                  w_wr_addr_nxt  = {w_phys_row, w_col_dec};
                  w_wr_data_nxt  = BLANK_CHAR;
                  w_step_col_nxt = 1'b0;
                  w_state_nxt    = ST_WRITE_CHAR;
                end
              end
              CHR_FF: begin
                w_col_nxt     = '0;
                w_row_nxt     = '0;
                w_offset_nxt  = '0;
                w_wr_addr_nxt = '0;
                w_wr_data_nxt = BLANK_CHAR;
                w_state_nxt   = ST_CLEAR_ALL;
              end
              default: ;
            endcase
          end
        end
      end

      ST_WRITE_CHAR: begin
        if (w_wr_en) begin
          w_state_nxt = ST_IDLE;
          if (r_step_col) begin
            if (r_col == COL_BITS'(COLS - 1)) begin
              w_col_nxt = '0;
              w_advance = 1'b1;
            end else begin
              w_col_nxt = r_col + 5'd1;
            end
          end
        end
      end

      // Offset moves only after the last blank lands, so a stale line never shows.
      ST_CLEAR_LINE: begin
        if (w_wr_en) begin
          if (r_wr_addr[COL_BITS-1:0] == COL_BITS'(COLS - 1)) begin
            w_offset_nxt = r_offset + 4'd1;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_wr_addr_nxt = r_wr_addr + 9'd1;
          end
        end
      end

      ST_CLEAR_ALL: begin
        if (w_wr_en) begin
          if (r_wr_addr == '1) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_wr_addr_nxt = r_wr_addr + 9'd1;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // Line advance: bottom row scrolls by blanking the current top line.
    if (w_advance) begin
      if (r_row != ROW_BITS'(ROWS - 1)) begin
        w_row_nxt   = r_row + 4'd1;
        w_state_nxt = ST_IDLE;
      end else begin
        w_wr_addr_nxt = {r_offset, {COL_BITS{1'b0}}};
        w_wr_data_nxt = BLANK_CHAR;
        w_state_nxt   = ST_CLEAR_LINE;
      end
    end
  end

  always_ff @(posedge i_pix_clk) begin
    if (!i_reset_n) begin
      r_state    <= ST_CLEAR_ALL;
      r_col      <= '0;
      r_row      <= '0;
      r_offset   <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= BLANK_CHAR;
      r_step_col <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_offset   <= w_offset_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_step_col <= w_step_col_nxt;
    end
  end

  assign o_char_ready = w_ready;
  assign o_wr_en      = w_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_row_offset = r_offset;
  assign o_cursor_col = r_col;
  assign o_cursor_row = r_row;
  assign o_busy       = (r_state != ST_IDLE);

`ifdef TEXT_CONSOLE_CURSOR_BLINK_EN
  cursor_blink_timer u_blink (
    .i_clk         (i_pix_clk),
    .i_reset_n     (i_reset_n),
    .i_frame_start (i_frame_start),
    .i_kick        (w_accept),
    .o_cursor_on   (o_cursor_on)
  );
`endif

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: a cursor/scroll reference model
// predicts every text-buffer write; a negedge monitor pops and compares.
module tb_text_console_ctrl;
  import text_console_defs::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       act = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] chr = 8'h00;
  logic       o_char_ready, o_wr_en, o_busy;
  logic [8:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic [3:0] o_row_offset, o_cursor_row;
  logic [4:0] o_cursor_col;
`ifdef TEXT_CONSOLE_CURSOR_BLINK_EN
  logic       frame_start = 1'b0;
  logic       cursor_on;
`endif

  always #5 clk = ~clk;

  text_console_ctrl dut (
    .i_pix_clk        (clk),
    .i_reset_n        (rst_n),
    .i_in_active_area (act),
    .i_char_valid     (valid),
    .i_char           (chr),
    .o_char_ready     (o_char_ready),
    .o_wr_en          (o_wr_en),
    .o_wr_addr        (o_wr_addr),
    .o_wr_data        (o_wr_data),
    .o_row_offset     (o_row_offset),
    .o_cursor_col     (o_cursor_col),
    .o_cursor_row     (o_cursor_row),
    .o_busy           (o_busy)
`ifdef TEXT_CONSOLE_CURSOR_BLINK_EN
    ,
    .i_frame_start    (frame_start),
    .o_cursor_on      (cursor_on)
`endif
  );

  typedef struct packed { logic [8:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  pops     = 0;
  int  act_mode = 0;   // 0: outside area, 1: random blanking, 2: always active
  int  m_col = 0, m_row = 0, m_off = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] r);
    n_checks++;
    if (a !== r) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, r);
    end
  endtask

  // Reference model: screen geometry and control-code rules in plain arithmetic.
  task automatic push_w(input int row, input int col, input logic [7:0] d);
    wr_t w;
    w.a = {4'(row), 5'(col)};
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic m_advance();
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int c = 0; c < COLS; c++) push_w(m_off, c, BLANK_CHAR);
      m_off = (m_off + 1) % ROWS;
    end
  endtask

  task automatic m_clear_all();
    for (int i = 0; i < COLS * ROWS; i++) push_w(i / COLS, i % COLS, BLANK_CHAR);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_w((m_row + m_off) % ROWS, m_col, b);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_advance();
      end
    end else if (b == 8'h0A) begin
      m_col = 0;
      m_advance();
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_w((m_row + m_off) % ROWS, m_col, BLANK_CHAR);
      end
    end else if (b == 8'h0C) begin
      m_col = 0; m_row = 0; m_off = 0;
      m_clear_all();
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    case (act_mode)
      0:       act = 1'b0;
      1:       act = ($urandom_range(0, 3) == 0);
      default: act = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (o_wr_en) begin
      wr_t e;
      if (act) begin
        n_checks++; n_fail++;
        $display("FAIL wr_in_active actual=1 required=0");
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write actual=%h/%h required=none", o_wr_addr, o_wr_data);
      end else begin
        e = exp_q.pop_front();
        pops++;
        if ({o_wr_addr, o_wr_data} !== {e.a, e.d}) begin
          n_fail++;
          $display("FAIL write actual=%h/%h required=%h/%h", o_wr_addr, o_wr_data, e.a, e.d);
        end
      end
    end
  end

  task automatic do_reset(input int cyc);
    @(posedge clk); #1;
    rst_n = 1'b0; valid = 1'b0;
    exp_q.delete();
    m_col = 0; m_row = 0; m_off = 0;
    repeat (cyc) begin
      @(negedge clk);
      chk("reset_wr_en", o_wr_en, 0);
      chk("reset_ready", o_char_ready, 0);
    end
    chk("reset_addr", o_wr_addr, 0);
    chk("reset_data", o_wr_data, BLANK_CHAR);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_clear_all();
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(posedge clk); #1;
    chr = b; valid = 1'b1;
    forever begin
      @(negedge clk);
      if (o_char_ready) begin
        model_byte(b);
        break;
      end
      if (++t > 5000) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout actual=busy required=ready");
        break;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0;
    chr = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    forever begin
      @(negedge clk);
      if (!o_busy && exp_q.size() == 0) break;
      if (++t > 4000) begin
        n_checks++; n_fail++;
        $display("FAIL idle_timeout actual=%0d pending required=0", exp_q.size());
        break;
      end
    end
  endtask

  task automatic check_cursor(input string nm);
    chk({nm, "_col"}, o_cursor_col, m_col);
    chk({nm, "_row"}, o_cursor_row, m_row);
    chk({nm, "_off"}, o_row_offset, m_off);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [7:0] b;

    // Reset and initial full clear
    do_reset(3);
    wait_idle();
    chk("init_ready", o_char_ready, 1);
    chk("init_busy", o_busy, 0);
    check_cursor("init");

    // Single char, then a char held off by the active area
    send(8'h41);
    wait_idle();
    chk("a_col", o_cursor_col, 1);
    @(negedge clk); act_mode = 2;
    send(8'h42);
    repeat (10) begin
      @(negedge clk);
      chk("stall_wr_en", o_wr_en, 0);
      chk("stall_addr", o_wr_addr, 9'd1);
    end
    act_mode = 0;
    wait_idle();
    check_cursor("stall");

    // Line wrap, backspace, carriage return
    send(8'h0C); wait_idle();
    for (int i = 0; i < 32; i++) send(8'h30 + 8'(i % 40));
    wait_idle();
    check_cursor("wrap");
    repeat (5) send(8'h41);
    send(8'h08);
    wait_idle();
    chk("bs_col", o_cursor_col, 4);
    send(8'h0D);
    wait_idle();
    check_cursor("cr");

    // Scroll at the bottom row
    send(8'h0C); wait_idle();
    repeat (15) send(8'h0A);
    wait_idle();
    chk("lf15_row", o_cursor_row, 15);
    send(8'h0A);
    wait_idle();
    chk("scroll_off", o_row_offset, 1);
    send(8'h43);
    wait_idle();
    check_cursor("scroll");

    // Reset in the middle of a line clear
    p0 = pops;
    send(8'h0A);
    for (int t = 0; t < 200 && pops < p0 + 10; t++) @(negedge clk);
    chk("mid_clear_pops", pops - p0, 10);
    do_reset(2);
    wait_idle();
    check_cursor("reclear");

    // Form feed mid-screen with random blanking, then an ignored byte
    act_mode = 1;
    send(8'h58); send(8'h0A); send(8'h59);
    send(8'h0C);
    wait_idle();
    check_cursor("ff");
    send(8'h07);
    repeat (3) begin
      @(negedge clk);
      chk("ign_ready", o_char_ready, 1);
      chk("ign_busy", o_busy, 0);
    end
    check_cursor("ignored");

    // Randomized byte stream
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 60)      b = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 72) b = CHR_LF;
      else if (r < 82) b = CHR_BS;
      else if (r < 89) b = CHR_CR;
      else if (r < 91) b = CHR_FF;
      else if (r < 96) b = 8'($urandom_range(0, 8'h1F));
      else             b = 8'($urandom_range(8'h7F, 8'hFF));
      send(b);
      if (i % 25 == 24) begin
        wait_idle();
        check_cursor("rand");
      end
    end
    wait_idle();
    check_cursor("final");
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
